// File: rtl/frv_pipeline_fetch.sv
// Instruction fetch stage: issues sequential word fetches, buffers responses and presents them to decode.
// Defining FRV_FETCH_BYPASS_EN forwards a response straight to s1 when the buffer is empty.
module frv_pipeline_fetch #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
  parameter int          FETCH_DEPTH        = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        imem_cen,
  output logic [31:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_error,
  input  logic [31:0] imem_rdata,
  output logic        s1_p_valid,
  input  logic        s1_p_busy,
  output logic [31:0] s1_data,
  output logic [31:0] s1_pc,
  output logic        s1_half,
  output logic        s1_error
);

  localparam int PTR_W = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FETCH_DEPTH);

  logic [31:0]      pc_reg;
  logic [31:0]      resp_pc_reg;
  logic             outstanding_reg;
  logic             discard_reg;
  logic             err_stop_reg;
  logic             half_reg;
  logic             hold_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0] data_mem  [FETCH_DEPTH];
  logic [31:0] pc_mem    [FETCH_DEPTH];
  logic        err_mem   [FETCH_DEPTH];
  logic        half_mem  [FETCH_DEPTH];

  logic [CNT_W:0] occupancy;
  logic           room;
  logic           resp_live;
  logic           resp_taken;
  logic           fetch_ok;
  logic           accept;
  logic           buf_empty;
  logic           push;
  logic           pop;
  logic           unused_target_bit;

  assign unused_target_bit = cf_target[0];

  assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, outstanding_reg};
  assign room      = occupancy < DEPTH_C;
  assign resp_live = outstanding_reg & ~discard_reg;
  assign buf_empty = (count_reg == '0);

  // An error arriving this cycle already blocks the next request; a held stalled request
  // never coincides with a response, so the hold path needs no such gate.
  assign fetch_ok  = ~err_stop_reg & ~(resp_live & imem_error) & room & ~cf_req;
  assign imem_cen  = ~g_reset & (hold_reg | fetch_ok);
  assign imem_addr = pc_reg;
  assign cf_ack    = cf_req & ~(imem_cen & imem_stall) & ~g_reset;
  assign accept    = imem_cen & ~imem_stall;

  // A response landing in the redirect cycle belongs to the old flow and is dropped.
  assign resp_taken = resp_live & ~cf_ack;

`ifdef FRV_FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = buf_empty & resp_taken & ~g_reset;
  assign s1_p_valid = ~g_reset & (~buf_empty | bypass);
  assign s1_data    = bypass ? imem_rdata  : data_mem[rd_ptr_reg];
  assign s1_pc      = bypass ? resp_pc_reg : pc_mem[rd_ptr_reg];
  assign s1_half    = bypass ? half_reg    : half_mem[rd_ptr_reg];
  assign s1_error   = bypass ? imem_error  : err_mem[rd_ptr_reg];
  assign push       = resp_taken & ~(bypass & ~s1_p_busy);
`else
  assign s1_p_valid = ~g_reset & ~buf_empty;
  assign s1_data    = data_mem[rd_ptr_reg];
  assign s1_pc      = pc_mem[rd_ptr_reg];
  assign s1_half    = half_mem[rd_ptr_reg];
  assign s1_error   = err_mem[rd_ptr_reg];
  assign push       = resp_taken;
`endif

  assign pop = s1_p_valid & ~s1_p_busy & ~buf_empty;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      pc_reg          <= {FRV_PC_RESET_VALUE[31:2], 2'b00};
      resp_pc_reg     <= '0;
      outstanding_reg <= 1'b0;
      discard_reg     <= 1'b0;
      err_stop_reg    <= 1'b0;
      half_reg        <= 1'b0;
      hold_reg        <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      hold_reg        <= imem_cen & imem_stall;
      outstanding_reg <= accept;
      discard_reg     <= accept & cf_ack;
      if (accept) begin
        resp_pc_reg <= pc_reg;
      end
      if (cf_ack) begin
        pc_reg       <= {cf_target[31:2], 2'b00};
        half_reg     <= cf_target[1];
        err_stop_reg <= 1'b0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        if (accept) begin
          pc_reg <= pc_reg + 32'd4;
        end
        if (resp_taken) begin
          half_reg <= 1'b0;
          if (imem_error) begin
            err_stop_reg <= 1'b1;
          end
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge g_clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
      err_mem[wr_ptr_reg]  <= imem_error;
      half_mem[wr_ptr_reg] <= half_reg;
    end
  end

endmodule

// File: tb/tb_frv_pipeline_fetch.sv
// Directed bench for frv_pipeline_fetch: a one-cycle-latency memory model returns ~addr as data.
module tb_frv_pipeline_fetch;

  logic        g_clk;
  logic        g_reset;
  logic        cf_req;
  logic [31:0] cf_target;
  logic        cf_ack;
  logic        imem_cen;
  logic [31:0] imem_addr;
  logic        imem_stall;
  logic        imem_error;
  logic [31:0] imem_rdata;
  logic        s1_p_valid;
  logic        s1_p_busy;
  logic [31:0] s1_data;
  logic [31:0] s1_pc;
  logic        s1_half;
  logic        s1_error;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] err_addr = 32'h0000_0001;

  frv_pipeline_fetch #(
    .FRV_PC_RESET_VALUE(32'h8000_0000),
    .FETCH_DEPTH(4)
  ) dut (
    .g_clk(g_clk),
    .g_reset(g_reset),
    .cf_req(cf_req),
    .cf_target(cf_target),
    .cf_ack(cf_ack),
    .imem_cen(imem_cen),
    .imem_addr(imem_addr),
    .imem_stall(imem_stall),
    .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .s1_p_valid(s1_p_valid),
    .s1_p_busy(s1_p_busy),
    .s1_data(s1_data),
    .s1_pc(s1_pc),
    .s1_half(s1_half),
    .s1_error(s1_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge g_clk) begin
    if (!g_reset && s1_p_valid === 1'b1 && s1_p_busy === 1'b0)
      $display("pop pc=%08h data=%08h half=%0d err=%0d", s1_pc, s1_data, s1_half, s1_error);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory model answers an accepted request one cycle later.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = (imem_cen === 1'b1) && (imem_stall === 1'b0);
    acc_addr = imem_addr;
    @(posedge g_clk);
    #1;
    imem_rdata = acc ? ~acc_addr : 32'h0;
    imem_error = acc && (acc_addr == err_addr);
  endtask

  task automatic do_reset();
    g_reset    = 1'b1;
    cf_req     = 1'b0;
    imem_stall = 1'b0;
    s1_p_busy  = 1'b0;
    tick();
    tick();
    g_reset = 1'b0;
  endtask

  initial begin
    g_reset    = 1'b1;
    cf_req     = 1'b0;
    cf_target  = 32'h0;
    imem_stall = 1'b0;
    imem_error = 1'b0;
    imem_rdata = 32'h0;
    s1_p_busy  = 1'b0;
    #2;
    cf_req = 1'b1;
    tick(); #1;
    chk("rst_cen", imem_cen, 1'b0);
    chk("rst_valid", s1_p_valid, 1'b0);
    chk("rst_ack", cf_ack, 1'b0);
    cf_req = 1'b0;

    // Sequential fetch from reset vector
    tick(); g_reset = 1'b0; #1;
    chk("seq_cen0", imem_cen, 1'b1);
    chk("seq_addr0", imem_addr, 32'h8000_0000);
    tick(); #1;
    chk("seq_valid_lat", s1_p_valid, 1'b0);
    chk("seq_addr1", imem_addr, 32'h8000_0004);
    tick(); #1;
    chk("seq_valid", s1_p_valid, 1'b1);
    chk("seq_pc0", s1_pc, 32'h8000_0000);
    chk("seq_data0", s1_data, 32'h7FFF_FFFF);
    chk("seq_half0", s1_half, 1'b0);
    chk("seq_err0", s1_error, 1'b0);
    chk("seq_addr2", imem_addr, 32'h8000_0008);
    tick(); #1;
    chk("seq_pc1", s1_pc, 32'h8000_0004);

    // Back-pressure fills the buffer to depth
    tick(); s1_p_busy = 1'b1; #1;
    chk("seq_pc2", s1_pc, 32'h8000_0008);
    chk("bp_addr4", imem_addr, 32'h8000_0010);
    tick(); #1;
    chk("bp_addr5", imem_addr, 32'h8000_0014);
    tick(); #1;
    chk("bp_cen_off6", imem_cen, 1'b0);
    tick(); #1;
    chk("bp_cen_off7", imem_cen, 1'b0);
    chk("bp_head7", s1_pc, 32'h8000_0008);
    tick(); s1_p_busy = 1'b0; #1;
    chk("bp_cen_off8", imem_cen, 1'b0);
    chk("bp_pop0", s1_pc, 32'h8000_0008);
    tick(); #1;
    chk("bp_pop1", s1_pc, 32'h8000_000C);
    chk("bp_resume_cen", imem_cen, 1'b1);
    chk("bp_resume_addr", imem_addr, 32'h8000_0018);
    tick(); #1;
    chk("bp_pop2", s1_pc, 32'h8000_0010);
    tick(); #1;
    chk("bp_pop3", s1_pc, 32'h8000_0014);
    tick(); #1;
    chk("bp_next_pc", s1_pc, 32'h8000_0018);
    chk("bp_next_data", s1_data, 32'h7FFF_FFE7);

    // Redirect held off by a stalled request, halfword target
    do_reset();
    imem_stall = 1'b1; #1;
    chk("st_cen", imem_cen, 1'b1);
    tick(); cf_req = 1'b1; cf_target = 32'h0000_1002; #1;
    chk("st_ack_c1", cf_ack, 1'b0);
    chk("st_cen_hold", imem_cen, 1'b1);
    tick(); #1;
    chk("st_ack_c2", cf_ack, 1'b0);
    tick(); #1;
    chk("st_ack_c3", cf_ack, 1'b0);
    chk("st_addr_hold", imem_addr, 32'h8000_0000);
    tick(); imem_stall = 1'b0; #1;
    chk("st_ack_go", cf_ack, 1'b1);
    tick(); cf_req = 1'b0; #1;
    chk("st_new_cen", imem_cen, 1'b1);
    chk("st_new_addr", imem_addr, 32'h0000_1000);
    chk("st_valid_c5", s1_p_valid, 1'b0);
    tick(); #1;
    chk("st_valid_c6", s1_p_valid, 1'b0);
    tick(); #1;
    chk("st_valid_c7", s1_p_valid, 1'b1);
    chk("st_pc", s1_pc, 32'h0000_1000);
    chk("st_half", s1_half, 1'b1);
    chk("st_data", s1_data, 32'hFFFF_EFFF);
    tick(); #1;
    chk("st_pc_next", s1_pc, 32'h0000_1004);
    chk("st_half_next", s1_half, 1'b0);

    // Redirect right after an accepted request flushes buffer and drops the response
    do_reset();
    s1_p_busy = 1'b1; #1;
    tick(); #1;
    tick(); #1;
    tick(); cf_req = 1'b1; cf_target = 32'h0000_2000; #1;
    chk("fl_ack", cf_ack, 1'b1);
    chk("fl_cen_ack", imem_cen, 1'b0);
    chk("fl_valid_pre", s1_p_valid, 1'b1);
    chk("fl_pc_pre", s1_pc, 32'h8000_0000);
    tick(); cf_req = 1'b0; s1_p_busy = 1'b0; #1;
    chk("fl_valid_c4", s1_p_valid, 1'b0);
    chk("fl_addr", imem_addr, 32'h0000_2000);
    tick(); #1;
    chk("fl_valid_c5", s1_p_valid, 1'b0);
    tick(); #1;
    chk("fl_pc", s1_pc, 32'h0000_2000);
    chk("fl_data", s1_data, 32'hFFFF_DFFF);
    tick(); #1;
    chk("fl_pc_next", s1_pc, 32'h0000_2004);

    // Error response stops fetching until the next redirect
    do_reset();
    err_addr = 32'h8000_0004; #1;
    tick(); #1;
    chk("er_addr1", imem_addr, 32'h8000_0004);
    tick(); #1;
    chk("er_cen_stop", imem_cen, 1'b0);
    chk("er_pc0", s1_pc, 32'h8000_0000);
    chk("er_err0", s1_error, 1'b0);
    tick(); #1;
    chk("er_pc1", s1_pc, 32'h8000_0004);
    chk("er_err1", s1_error, 1'b1);
    tick(); #1;
    chk("er_valid_c4", s1_p_valid, 1'b0);
    chk("er_cen_c4", imem_cen, 1'b0);
    tick(); #1;
    chk("er_cen_c5", imem_cen, 1'b0);
    err_addr = 32'h0000_0001;
    tick(); cf_req = 1'b1; cf_target = 32'h0000_0100; #1;
    chk("er_ack", cf_ack, 1'b1);
    tick(); cf_req = 1'b0; #1;
    chk("er_resume_cen", imem_cen, 1'b1);
    chk("er_resume_addr", imem_addr, 32'h0000_0100);
    tick(); #1;
    tick(); #1;
    chk("er_new_pc", s1_pc, 32'h0000_0100);
    chk("er_new_err", s1_error, 1'b0);

    // Reset with three buffered entries
    do_reset();
    s1_p_busy = 1'b1; #1;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chk("rb_cen_full", imem_cen, 1'b0);
    chk("rb_valid", s1_p_valid, 1'b1);
    g_reset = 1'b1; #1;
    chk("rb_valid_rst", s1_p_valid, 1'b0);
    tick(); g_reset = 1'b0; s1_p_busy = 1'b0; #1;
    chk("rb_valid_after", s1_p_valid, 1'b0);
    chk("rb_cen", imem_cen, 1'b1);
    chk("rb_addr", imem_addr, 32'h8000_0000);
    tick(); #1;
    chk("rb_valid_c6", s1_p_valid, 1'b0);
    tick(); #1;
    chk("rb_pc", s1_pc, 32'h8000_0000);

    // Address wraps modulo 2^32
    do_reset();
    cf_req = 1'b1; cf_target = 32'hFFFF_FFFE; #1;
    chk("wr_ack", cf_ack, 1'b1);
    chk("wr_cen_ack", imem_cen, 1'b0);
    tick(); cf_req = 1'b0; #1;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wr_addr1", imem_addr, 32'h0000_0000);
    tick(); #1;
    chk("wr_pc0", s1_pc, 32'hFFFF_FFFC);
    chk("wr_half0", s1_half, 1'b1);
    chk("wr_data0", s1_data, 32'h0000_0003);
    tick(); #1;
    chk("wr_pc1", s1_pc, 32'h0000_0000);
    chk("wr_half1", s1_half, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frv_pipeline_fetch.md
FRV_PIPELINE_FETCH -- requirements
Module: frv_pipeline_fetch

Interface
REQ-001 SHALL have parameter FRV_PC_RESET_VALUE, default 32'h8000_0000, address of the first fetch after reset.
REQ-002 SHALL have parameter FETCH_DEPTH, default 4, the number of fetch buffer entries (power of two, at least 2).
REQ-003 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port g_reset, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port cf_req, input, 1 bit: control flow change request from the backend.
REQ-006 SHALL have port cf_target, input, 32 bits: control flow change target.
REQ-007 SHALL have port cf_ack, output, 1 bit: control flow change acknowledge.
REQ-008 SHALL have port imem_cen, output, 1 bit: instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32 bits: request word address, bits [1:0] always 0.
REQ-010 SHALL have port imem_stall, input, 1 bit: memory not accepting the request this cycle.
REQ-011 SHALL have port imem_error, input, 1 bit: response error, valid with the response.
REQ-012 SHALL have port imem_rdata, input, 32 bits: response data.
REQ-013 SHALL have port s1_p_valid, output, 1 bit: a buffered word is presented to decode.
REQ-014 SHALL have port s1_p_busy, input, 1 bit: decode cannot accept this cycle.
REQ-015 SHALL have port s1_data, output, 32 bits: the presented instruction word.
REQ-016 SHALL have port s1_pc, output, 32 bits: address of the presented word.
REQ-017 SHALL have port s1_half, output, 1 bit: only bits [31:16] of the presented word are valid, because the redirect target was halfword-aligned.
REQ-018 SHALL have port s1_error, output, 1 bit: the presented word returned imem_error.

Function
REQ-019 SHALL treat a request as accepted in the cycle imem_cen=1 and imem_stall=0; the response arrives exactly one cycle later; at most one response is outstanding at a time.
REQ-020 SHALL hold imem_cen and imem_addr stable while imem_cen=1 and imem_stall=1.
REQ-021 SHALL assert imem_cen only when buffered entries plus the outstanding response count is less than FETCH_DEPTH, and no error word has been fetched since the last redirect.
REQ-022 SHALL increment the fetch address by 4 on each accepted request, wrapping modulo 2^32.
REQ-023 SHALL push each response into the buffer as {imem_error, pc, imem_rdata, half}, unless that response is marked discarded.
REQ-024 SHALL present the oldest buffer entry on the s1 outputs with s1_p_valid=1 whenever the buffer is non-empty.
REQ-025 SHALL pop the presented entry when s1_p_valid=1 and s1_p_busy=0; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-026 SHALL drive cf_ack = cf_req AND NOT (imem_cen AND imem_stall) AND NOT g_reset.
REQ-027 On cf_req=1 and cf_ack=1, SHALL:
  - empty the buffer;
  - mark any outstanding response as discarded;
  - set the fetch address to {cf_target[31:2], 2'b00};
  - set the half flag of the next pushed entry to cf_target[1];
  - clear the error-stop condition.
REQ-028 SHALL NOT issue a request in the cycle of cf_ack; the first request to the new target is issued the following cycle.
REQ-029 After an entry with error=1 is pushed, SHALL issue no further requests until the next cf_ack.
REQ-030 Boundary: when the buffer is full, imem_cen=0; when the buffer is empty, s1_p_valid=0; while cf_req is held un-acknowledged, no new requests are issued.

Reset
REQ-031 While g_reset=1, SHALL drive imem_cen=0, s1_p_valid=0 and cf_ack=0, empty the buffer, clear the discard and error flags, and set the fetch address to FRV_PC_RESET_VALUE.
REQ-032 In the first cycle after g_reset falls, SHALL drive imem_cen=1 and imem_addr=FRV_PC_RESET_VALUE.
REQ-033 A response arriving in the cycle after reset asserted mid-request SHALL be dropped.

Configuration
REQ-034 With macro FRV_FETCH_BYPASS_EN defined, a non-discarded response arriving while the buffer is empty SHALL be presented on s1 in the same cycle; if s1_p_busy=0 in that cycle it SHALL NOT be written to the buffer.
REQ-035 Without FRV_FETCH_BYPASS_EN, every response SHALL pass through the buffer, so s1_p_valid rises no earlier than one cycle after the response.

Verification
REQ-036 Reset release, no stall, s1_p_busy=0 -> requests issued to 8000_0000, 8000_0004, 8000_0008; s1_pc follows the same sequence in order.
REQ-037 Hold s1_p_busy=1 with FETCH_DEPTH=4 -> exactly 4 entries buffered, imem_cen=0 afterwards; release s1_p_busy -> 4 pops on consecutive cycles, then fetching resumes.
REQ-038 Raise cf_req with cf_target=0000_1002 while imem_stall=1 for 3 cycles -> cf_ack stays 0 for those 3 cycles; then the buffer is flushed, the next request is to 0000_1000, and its entry has s1_half=1.
REQ-039 Raise cf_ack in the cycle after a request is accepted -> that response is discarded and never presented on s1.
REQ-040 Return imem_error=1 for the request to 8000_0004 -> that entry has s1_error=1 and no further requests are issued; cf_ack to 0000_0100 -> fetching resumes at 0000_0100.
REQ-041 Assert g_reset while the buffer holds 3 entries -> s1_p_valid=0 in the next cycle; after release, the first request is to 8000_0000.
